// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR coefficient sizes, types, default set and bank FSM states
package fir_pkg;

  localparam int NUM_COEF = 11;
  localparam int COEF_W   = 18;
  localparam int ADDR_W   = 4;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } bank_state_t;

  // Index 0 is the outer tap, NUM_COEF-1 the centre tap.
  localparam coef_t DEFAULT_COEF [NUM_COEF] = '{
    coef_t'(4095),   coef_t'(5901),   coef_t'(3327),  coef_t'(-3449),
    coef_t'(-10679), coef_t'(-12461), coef_t'(-4028), coef_t'(14916),
    coef_t'(38992),  coef_t'(59144),  coef_t'(66992)
  };

endpackage

// File: rtl/fir_coef_bank_ctrl_if.sv
// rtl/fir_coef_bank_ctrl_if.sv - host write channel into the coefficient shadow bank
interface fir_coef_bank_ctrl_if;
  import fir_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  coef_t             wr_data;
  logic              wr_last;

  modport master (output wr_valid, wr_addr, wr_data, wr_last, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, wr_last, output wr_ready);

endinterface

// File: rtl/fir_coef_shadow.sv
// rtl/fir_coef_shadow.sv - shadow coefficient register file with per-entry written mask
module fir_coef_shadow
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  coef_t             wr_data,
  input  logic              clear,
  output coef_t             shadow [NUM_COEF],
  output logic              complete
);

  logic [NUM_COEF-1:0] mask;
  logic [NUM_COEF-1:0] wr_hot;

  // One-hot of the entry being written this cycle (zero when no write)
  always_comb begin
    wr_hot = '0;
    if (wr_en) wr_hot = NUM_COEF'(1) << wr_addr;
  end

  // Completeness includes the write landing this cycle, so wr_last can be judged immediately
  assign complete = &(mask | wr_hot);

  // Shadow data: last write to an entry wins; contents survive a mask clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_COEF; i++) shadow[i] <= '0;
    end else if (wr_en) begin
      shadow[wr_addr] <= wr_data;
    end
  end

  // Written mask: clear takes priority over a same-cycle write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     mask <= '0;
    else if (clear) mask <= '0;
    else            mask <= mask | wr_hot;
  end

endmodule

// File: rtl/fir_coef_bank_ctrl.sv
// rtl/fir_coef_bank_ctrl.sv - commits a complete host coefficient set to the active bank on a sample boundary
module fir_coef_bank_ctrl
  import fir_pkg::*;
#(
  parameter int VER_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       samp_en,
  input  logic                       abort,
  fir_coef_bank_ctrl_if.slave        wr,
  output logic [NUM_COEF*COEF_W-1:0] coef_out,
  output logic                       swap_done,
  output logic                       err,
  output logic [VER_W-1:0]           coef_ver
);

  bank_state_t state, next_state;

  logic  wr_ready_q;
  logic  accept;
  logic  addr_ok;
  logic  shadow_wr;
  logic  mask_clr;
  logic  commit;
  logic  err_set;
  logic  complete;
  coef_t shadow [NUM_COEF];
  coef_t active [NUM_COEF];

  // Abort has priority over any write presented in the same cycle
  assign accept    = wr.wr_valid & wr_ready_q & ~abort;
  assign addr_ok   = wr.wr_addr < ADDR_W'(NUM_COEF);
  assign shadow_wr = (state == IDLE) & accept & addr_ok;

  fir_coef_shadow u_shadow (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (shadow_wr),
    .wr_addr  (wr.wr_addr),
    .wr_data  (wr.wr_data),
    .clear    (mask_clr),
    .shadow   (shadow),
    .complete (complete)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next state: arm on a complete set, leave ARMED on abort or sample strobe
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (shadow_wr && wr.wr_last && complete) next_state = ARMED;
      ARMED:   if (abort || samp_en) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control decode: mask clearing, commit and error requests
  always_comb begin
    mask_clr = 1'b0;
    commit   = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (abort) begin
          mask_clr = 1'b1;
        end else if (accept) begin
          if (!addr_ok) begin
            err_set = 1'b1;
          end else if (wr.wr_last && !complete) begin
            err_set  = 1'b1;
            mask_clr = 1'b1;
          end
        end
      end
      ARMED: begin
        if (abort) begin
          mask_clr = 1'b1;
        end else if (samp_en) begin
          commit   = 1'b1;
          mask_clr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered ready: open only while the next state is IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wr_ready_q <= 1'b1;
    else        wr_ready_q <= (next_state == IDLE);
  end

  assign wr.wr_ready = wr_ready_q;

  // One-cycle status pulses, the cycle after the triggering edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      swap_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      swap_done <= commit;
      err       <= err_set;
    end
  end

  // Active bank: whole-set copy from shadow only on commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      active <= DEFAULT_COEF;
    else if (commit) active <= shadow;
  end

  // Commit version counter, wraps modulo 2**VER_W
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      coef_ver <= '0;
    else if (commit) coef_ver <= coef_ver + VER_W'(1);
  end

  for (genvar i = 0; i < NUM_COEF; i++) begin : g_out
    assign coef_out[i*COEF_W +: COEF_W] = active[i];
  end

endmodule

// File: tb/tb_fir_coef_bank_ctrl.sv
// tb/tb_fir_coef_bank_ctrl.sv - self-checking bench for fir_coef_bank_ctrl
module tb_fir_coef_bank_ctrl;
  import fir_pkg::*;

  localparam int VER_W = 8;
  localparam int FLAT_W = NUM_COEF * COEF_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              samp_en = 1'b0;
  logic              abort = 1'b0;
  logic [FLAT_W-1:0] coef_out;
  logic              swap_done;
  logic              err;
  logic [VER_W-1:0]  coef_ver;

  fir_coef_bank_ctrl_if wr_if ();

  fir_coef_bank_ctrl #(.VER_W(VER_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .samp_en   (samp_en),
    .abort     (abort),
    .wr        (wr_if),
    .coef_out  (coef_out),
    .swap_done (swap_done),
    .err       (err),
    .coef_ver  (coef_ver)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        v;
    logic [ADDR_W-1:0] a;
    coef_t       d;
    logic        l;
    logic        ab;
    logic        exp_ready;
    logic        exp_err;
    logic        exp_swap;
  } vec_t;

  int dflt [NUM_COEF] = '{4095, 5901, 3327, -3449, -10679, -12461, -4028,
                          14916, 38992, 59144, 66992};

  int                n_cmp = 0;
  int                n_bad = 0;
  int                swap_seen = 0;
  int                err_seen = 0;
  vec_t              vt [$];
  logic [FLAT_W-1:0] sb_coef [$];
  logic [VER_W-1:0]  sb_ver [$];
  coef_t             ref_shadow [NUM_COEF];
  coef_t             ref_active [NUM_COEF];
  logic [VER_W-1:0]  ref_ver = '0;
  logic              mdl_ready;
  logic [FLAT_W-1:0] mon_exp;
  logic [VER_W-1:0]  mon_ver;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic coef_t field(input int i);
    return coef_t'(coef_out[i*COEF_W +: COEF_W]);
  endfunction

  function automatic logic [FLAT_W-1:0] pack_ref();
    logic [FLAT_W-1:0] f;
    for (int i = 0; i < NUM_COEF; i++) f[i*COEF_W +: COEF_W] = ref_shadow[i];
    return f;
  endfunction

  function automatic void add(input logic s, input logic v, input int a, input int d,
                              input logic l, input logic ab, input logic er,
                              input logic ee, input logic es);
    vec_t r;
    r.s = s; r.v = v; r.a = ADDR_W'(a); r.d = coef_t'(d); r.l = l; r.ab = ab;
    r.exp_ready = er; r.exp_err = ee; r.exp_swap = es;
    vt.push_back(r);
  endfunction

  task automatic drive(input logic s, input logic v, input logic [ADDR_W-1:0] a,
                       input coef_t d, input logic l, input logic ab);
    samp_en = s;
    wr_if.wr_valid = v;
    wr_if.wr_addr = a;
    wr_if.wr_data = d;
    wr_if.wr_last = l;
    abort = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic push_commit();
    ref_ver = ref_ver + VER_W'(1);
    sb_coef.push_back(pack_ref());
    sb_ver.push_back(ref_ver);
    ref_active = ref_shadow;
  endtask

  task automatic write_full(input int base, input int step);
    coef_t v;
    for (int i = 0; i < NUM_COEF; i++) begin
      v = coef_t'(base + step * i);
      ref_shadow[i] = v;
      drive(1'b0, 1'b1, ADDR_W'(i), v, (i == NUM_COEF - 1), 1'b0);
    end
  endtask

  task automatic commit_now();
    push_commit();
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_active(input string name);
    for (int i = 0; i < NUM_COEF; i++)
      chk($sformatf("%s_%0d", name, i), field(i), ref_active[i]);
  endtask

  // Scoreboard consumer: every swap_done pops one expected commit
  always @(negedge clk) begin
    if (swap_done === 1'b1) begin
      swap_seen++;
      if (sb_coef.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL swap_unexpected: got swap_done=1 required no swap");
      end else begin
        mon_exp = sb_coef.pop_front();
        mon_ver = sb_ver.pop_front();
        for (int i = 0; i < NUM_COEF; i++)
          chk($sformatf("swap_coef_%0d", i), field(i), coef_t'(mon_exp[i*COEF_W +: COEF_W]));
        chk("swap_ver", coef_ver, mon_ver);
      end
    end
    if (err === 1'b1) err_seen++;
    if (swap_done === 1'b1 || err === 1'b1) chk("swap_err_exclusive", swap_done & err, 0);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish required finish before 2ms");
    $fatal(1);
  end

  initial begin
    int s0;
    int e0;
    int n_wrap;

    // Table: partial set, stray strobe, bad address, rewrite, abort, strobe on wr_last
    for (int i = 0; i < 10; i++) add(0, 1, i, 1000 + i, i == 9, 0, 1, i == 9, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 1, i, -2000 - i, 0, 0, 1, 0, 0);
    add(0, 1, 3, 777, 0, 0, 1, 0, 0);
    add(0, 1, 12, 12345, 0, 0, 1, 1, 0);
    add(0, 1, 10, -50000, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 10; i++) add(0, 1, i, 300 + i, 0, 0, 1, 0, 0);
    add(0, 1, 10, 999, 1, 1, 1, 0, 0);
    add(0, 1, 10, 4244, 1, 0, 1, 1, 0);
    for (int i = 10; i >= 0; i--) add(i == 0, 1, i, 3 * i - 50000, i == 0, 0, i != 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 1, 15, 1, 1, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);

    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr = '0;
    wr_if.wr_data = '0;
    wr_if.wr_last = 1'b0;
    for (int i = 0; i < NUM_COEF; i++) begin
      ref_shadow[i] = '0;
      ref_active[i] = coef_t'(dflt[i]);
    end

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check_active("rst_coef");
    chk("rst_coef10", field(10), 66992);
    chk("rst_coef3", field(3), -3449);
    chk("rst_ver", coef_ver, 0);
    chk("rst_ready", wr_if.wr_ready, 1);
    chk("rst_swap", swap_done, 0);
    chk("rst_err", err, 0);

    // Full set of 8192, strobe five cycles later
    e0 = err_seen;
    write_full(8192, 0);
    chk("arm_ready", wr_if.wr_ready, 0);
    for (int k = 0; k < 5; k++) begin
      idle();
      chk($sformatf("armed_wait_ready_%0d", k), wr_if.wr_ready, 0);
      chk($sformatf("armed_wait_coef_%0d", k), field(0), 4095);
    end
    commit_now();
    chk("commit_ready", wr_if.wr_ready, 1);
    check_active("commit_coef");
    chk("commit_ver", coef_ver, 1);
    idle();
    chk("commit_swap_once", swap_seen, 1);
    chk("commit_no_err", err_seen, e0);

    // Table-driven vectors
    mdl_ready = 1'b1;
    for (int k = 0; k < vt.size(); k++) begin
      if (vt[k].v && mdl_ready && !vt[k].ab && (vt[k].a < ADDR_W'(NUM_COEF)))
        ref_shadow[vt[k].a] = vt[k].d;
      if (vt[k].exp_swap) push_commit();
      drive(vt[k].s, vt[k].v, vt[k].a, vt[k].d, vt[k].l, vt[k].ab);
      chk($sformatf("vec%0d_ready", k), wr_if.wr_ready, vt[k].exp_ready);
      chk($sformatf("vec%0d_err", k), err, vt[k].exp_err);
      chk($sformatf("vec%0d_swap", k), swap_done, vt[k].exp_swap);
      mdl_ready = vt[k].exp_ready;
    end
    check_active("table_coef");

    // Abort wins over a simultaneous strobe while armed
    s0 = swap_seen;
    e0 = err_seen;
    write_full(5555, 1);
    chk("abort_armed_ready", wr_if.wr_ready, 0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("abort_swap", swap_done, 0);
    chk("abort_err", err, 0);
    chk("abort_ready", wr_if.wr_ready, 1);
    idle();
    idle();
    check_active("abort_coef");
    chk("abort_no_swap", swap_seen, s0);
    chk("abort_no_err", err_seen, e0);

    // Commits until the version counter wraps to zero
    n_wrap = 256 - int'(ref_ver);
    for (int c = 0; c < n_wrap; c++) begin
      write_full(c * 7, 1 + c);
      commit_now();
    end
    idle();
    chk("ver_wrap", coef_ver, 0);
    check_active("wrap_coef");

    // Reset while armed restores defaults with no clock edge
    write_full(-7, -1000);
    chk("rstarm_ready", wr_if.wr_ready, 0);
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < NUM_COEF; i++) ref_active[i] = coef_t'(dflt[i]);
    check_active("rstarm_coef");
    chk("rstarm_ver", coef_ver, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle();
    chk("rstarm_ready_after", wr_if.wr_ready, 1);
    s0 = swap_seen;
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("rstarm_no_commit", swap_done, 0);
    idle();
    check_active("rstarm_final");
    chk("rstarm_swap_count", swap_seen, s0);

    idle();
    idle();
    chk("sb_drained", sb_coef.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_coef_bank_ctrl.md
Name: fir_coef_bank_ctrl

Overview:
- Coefficient bank controller for the 21-tap symmetric folded FIR (11 unique 0s18 coefficients).
- A host writes a complete new coefficient set into a shadow bank over a valid/ready handshake.
- The controller commits the set to the active bank, which drives the filter's coefficient inputs, only at a sample boundary (samp_en). The filter therefore never computes a sample with a mixed set.
- Sits between the host/config register interface and the FIR datapath.

Parameters:
- NUM_COEF, 11, number of unique coefficients (folded taps incl. centre)
- COEF_W, 18, coefficient width, signed 0s18
- ADDR_W, 4, write address width; must satisfy 2**ADDR_W >= NUM_COEF
- VER_W, 8, width of commit version counter

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- samp_en  in  1  one-cycle strobe marking the filter sample boundary
- wr_valid  in  1  host write request
- wr_ready  out  1  controller accepts write this cycle
- wr_addr  in  ADDR_W  coefficient index 0..NUM_COEF-1 (0 = outer tap, NUM_COEF-1 = centre)
- wr_data  in  COEF_W  signed coefficient value
- wr_last  in  1  marks final write of a set; requests commit
- abort  in  1  discard shadow contents and armed commit
- coef_out  out  NUM_COEF*COEF_W  active bank, flattened; index i at bits [i*COEF_W +: COEF_W]
- swap_done  out  1  one-cycle pulse, active bank updated
- err  out  1  one-cycle pulse on a rejected write or incomplete set
- coef_ver  out  VER_W  count of successful commits, wraps

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; shadow bank=0; written mask=0.
  - Active bank=DEFAULT_COEF (4095, 5901, 3327, -3449, -10679, -12461, -4028, 14916, 38992, 59144, 66992 for index 0..10).
  - wr_ready=1 after release; swap_done=0, err=0, coef_ver=0.
- Write handshake:
  - Transfer occurs when wr_valid & wr_ready on a rising edge.
  - wr_ready=1 only in IDLE. It is a registered function of state, independent of wr_valid.
- IDLE:
  - Accepted write with wr_addr < NUM_COEF: shadow[wr_addr] <= wr_data; mask[wr_addr] <= 1. Rewriting an address overwrites it; the last value wins.
  - Accepted write with wr_addr >= NUM_COEF: data dropped, err pulses next cycle, mask unchanged. If wr_last is set on that write, it is also ignored.
  - Accepted wr_last with a valid address: the write is applied first, then the complete mask is checked.
    - Mask all ones (including this write): go to ARMED.
    - Otherwise: err pulse, mask cleared, stay IDLE. Shadow contents are not cleared.
- ARMED:
  - wr_ready=0; waiting for samp_en.
  - samp_en=1 at edge t: active <= shadow, coef_ver <= coef_ver+1 (wraps 255->0), mask cleared, swap_done=1 for the cycle after t, state -> IDLE.
  - coef_out changes exactly at edge t and is registered; there is no combinational path from the shadow bank.
- Simultaneous events:
  - samp_en in the same cycle as the accepted wr_last: no commit on that strobe; commit happens on the next samp_en in ARMED.
  - abort in ARMED: -> IDLE, mask cleared, no swap, no err. abort wins over a simultaneous samp_en.
  - abort in IDLE: mask cleared. Any write in that same cycle is dropped (abort has priority). No err.
- Reset mid-operation: an armed or partial set is lost and the active bank returns to DEFAULT_COEF.
- No arithmetic on coefficient values; widths are passed through unchanged. The counter is unsigned modulo 2**VER_W.
- swap_done and err are mutually exclusive in any cycle.

Decomposition:
- Shared package fir_pkg:
  - COEF_W, NUM_COEF, ADDR_W.
  - coef_t (signed [COEF_W-1:0]).
  - DEFAULT_COEF constant array.
  - FSM state enum {IDLE, ARMED}.
- The FIR datapath imports the same package for its coefficient type.
- One natural sub-module: fir_coef_shadow (shadow register file plus written mask, with write/clear/complete outputs). The FSM, active bank and counter stay in the top.

Test Plan:
- Reset release -> coef_out index 10 = 66992, index 3 = -3449, coef_ver=0, wr_ready=1, no pulses.
- Write all 11 coefficients with value 8192, wr_last on addr 10, then samp_en 5 cycles later:
  - wr_ready=0 until the strobe.
  - All coef_out fields = 8192 at the strobe edge.
  - swap_done pulses once; coef_ver=1.
- Write addrs 0..9 only, wr_last on addr 9 -> err pulse, state stays IDLE, coef_out unchanged. A later full set commits normally.
- Write to addr 12 -> err pulse, shadow and mask unchanged, wr_ready stays 1.
- Full set armed, samp_en and abort asserted in the same cycle -> no swap_done, coef_out unchanged, wr_ready=1 the next cycle.
- 256 successful commits -> coef_ver wraps to 0. Also: assert reset while ARMED -> coef_out returns to DEFAULT_COEF immediately, without a clock edge.
